// File: rtl/hamming_secded_pkg.sv
// Shared definitions for the SECDED(8,4) code used by the hamming_secded
// datapath (encoder and decoder sides).
//   - Codeword bit positions (cw[7] is the overall parity bit p0).
//   - Error classification enum reported by the decoder.
//   - Syndrome, data extraction and encode helpers.
package hamming_secded_pkg;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;
  localparam int P0_IDX = 7;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    SINGLE = 2'd1,
    PARITY = 2'd2,
    DOUBLE = 2'd3
  } err_class_e;

  // Syndrome {s4,s2,s1}: each bit checks the Hamming positions (index+1)
  // that have that weight bit set, so a non-zero value names the bad bit.
  function automatic logic [2:0] calc_syndrome(input logic [7:0] cw);
    logic s1, s2, s4;
    s1 = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
    s2 = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
    s4 = cw[P4_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
    return {s4, s2, s1};
  endfunction

  function automatic logic [3:0] extract_data(input logic [7:0] cw);
    return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
  endfunction

  function automatic logic [7:0] encode_nibble(input logic [3:0] d);
    logic [7:0] cw;
    cw         = '0;
    cw[D0_IDX] = d[0];
    cw[D1_IDX] = d[1];
    cw[D2_IDX] = d[2];
    cw[D3_IDX] = d[3];
    cw[P1_IDX] = d[0] ^ d[1] ^ d[3];
    cw[P2_IDX] = d[0] ^ d[2] ^ d[3];
    cw[P4_IDX] = d[1] ^ d[2] ^ d[3];
    cw[P0_IDX] = ^cw[6:0];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_secded_dec8.sv
// Combinational SECDED(8,4) decoder.
// Ports:
//   i_cw    : 8-bit received codeword (cw[7] = overall parity).
//   o_data  : decoded nibble (corrected for single errors, raw for doubles).
//   o_class : CLEAN / SINGLE / PARITY / DOUBLE.
module hamming_secded_dec8
  import hamming_secded_pkg::*;
(
  input  logic [7:0] i_cw,
  output logic [3:0] o_data,
  output err_class_e o_class
);

  logic [2:0] w_syn;
  logic       w_q;
  logic [7:0] w_fixed;

  assign w_syn = calc_syndrome(i_cw);
  assign w_q   = ^i_cw;

  always_comb begin
    w_fixed = i_cw;
    o_class = CLEAN;
    if (w_syn != 3'd0 && w_q) begin
      // Odd overall parity with a syndrome: single error at position s.
      w_fixed[w_syn - 3'd1] = ~i_cw[w_syn - 3'd1];
      o_class               = SINGLE;
    end else if (w_syn == 3'd0 && w_q) begin
      o_class = PARITY;
    end else if (w_syn != 3'd0) begin
      o_class = DOUBLE;
    end
    o_data = extract_data(w_fixed);
  end

endmodule

// File: rtl/hamming_secded_stream_rx.sv
// Serial SECDED(8,4) link receiver: deserializes an LSB-first codeword
// stream, decodes it into a one-entry output buffer and keeps saturating
// error statistics plus sticky fault flags.
// Ports:
//   i_clk, i_rst                   : clock, synchronous active-high reset.
//   i_bit, i_bit_valid, i_sof      : serial input; i_sof marks cw[0].
//   o_data, o_valid, i_ready       : decoded nibble output buffer.
//   o_1bit/2bit/parity_error       : error class of the buffered word.
//   o_overflow, o_frame_abort      : sticky fault flags.
//   i_clr                          : clears counters and sticky flags.
//   o_cnt_1bit/2bit/parity         : saturating per-class counters.
//
// Output handshake: a word is transferred on every cycle where
// o_valid && i_ready; o_valid/o_data/flags hold steady until then. A word
// completing while o_valid && !i_ready is dropped (o_overflow); one
// completing during a transfer cycle replaces the departing word.
module hamming_secded_stream_rx
  import hamming_secded_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_bit,
  input  logic               i_bit_valid,
  input  logic               i_sof,
  output logic [3:0]         o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_1bit_error,
  output logic               o_2bit_error,
  output logic               o_parity_error,
  output logic               o_overflow,
  output logic               o_frame_abort,
  input  logic               i_clr,
  output logic [COUNT_W-1:0] o_cnt_1bit,
  output logic [COUNT_W-1:0] o_cnt_2bit,
  output logic [COUNT_W-1:0] o_cnt_parity
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e       r_state, w_state_nxt;
  logic [2:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]   r_shift, w_shift_nxt;
  logic         w_complete, w_abort;
  logic         w_stall, w_load, w_drop;
  logic [7:0]   w_cw;
  logic [3:0]   w_dec_data;
  err_class_e   w_dec_class;

  logic         r_valid;
  logic [3:0]   r_data;
  err_class_e   r_class;
  logic         r_overflow, r_frame_abort;
  logic [COUNT_W-1:0] r_cnt_1bit, r_cnt_2bit, r_cnt_parity;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // The 8th bit is decoded straight off the wire so the word lands in the
  // output register on the same edge that accepts it.
  assign w_cw = {i_bit, r_shift};

  hamming_secded_dec8 u_dec (
    .i_cw    (w_cw),
    .o_data  (w_dec_data),
    .o_class (w_dec_class)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_complete    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_bit_valid && i_sof) begin
          w_shift_nxt   = {6'd0, i_bit};
          w_bit_cnt_nxt = 3'd1;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_bit_valid) begin
          if (i_sof) begin
            // Mid-frame start: drop the partial word and restart.
            w_abort       = 1'b1;
            w_shift_nxt   = {6'd0, i_bit};
            w_bit_cnt_nxt = 3'd1;
          end else if (r_bit_cnt == 3'd7) begin
            w_complete    = 1'b1;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_shift_nxt[r_bit_cnt] = i_bit;
            w_bit_cnt_nxt          = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  assign w_stall = r_valid && !i_ready;
  assign w_load  = w_complete && !w_stall;
  assign w_drop  = w_complete && w_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 4'd0;
      r_class <= CLEAN;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_dec_data;
      r_class <= w_dec_class;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Clear takes priority over any same-cycle event.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_overflow    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_cnt_1bit    <= '0;
      r_cnt_2bit    <= '0;
      r_cnt_parity  <= '0;
    end else begin
      if (w_drop)  r_overflow    <= 1'b1;
      if (w_abort) r_frame_abort <= 1'b1;
      if (w_load) begin
        case (w_dec_class)
          SINGLE:  r_cnt_1bit   <= sat_inc(r_cnt_1bit);
          DOUBLE:  r_cnt_2bit   <= sat_inc(r_cnt_2bit);
          PARITY:  r_cnt_parity <= sat_inc(r_cnt_parity);
          default: ;
        endcase
      end
    end
  end

  assign o_valid        = r_valid;
  assign o_data         = r_data;
  assign o_1bit_error   = (r_class == SINGLE);
  assign o_2bit_error   = (r_class == DOUBLE);
  assign o_parity_error = (r_class == PARITY);
  assign o_overflow     = r_overflow;
  assign o_frame_abort  = r_frame_abort;
  assign o_cnt_1bit     = r_cnt_1bit;
  assign o_cnt_2bit     = r_cnt_2bit;
  assign o_cnt_parity   = r_cnt_parity;

endmodule
